simt_operand_collector: RTL and testbench

SIMT_OPERAND_COLLECTOR -- requirements
Module: simt_operand_collector

---
 rtl/simt_operand_collector_pkg.sv | 16 +
 rtl/simt_operand_collector.sv | 129 ++++++++++++
 tb/tb_simt_operand_collector.sv | 204 ++++++++++++++++++++
 3 files changed

// File: rtl/simt_operand_collector_pkg.sv
// Shared defaults and state encoding for the SIMT operand collector.
// Holds the lane geometry and the collector FSM states.
package simt_pkg;

  localparam int SIMT_LANES      = 32;
  localparam int SIMT_WIDTH      = 32;
  localparam int SIMT_BEAT_LANES = 8;
  localparam int SIMT_WID_W      = 5;

  typedef enum logic [1:0] {
    COLLECT_A = 2'd0,
    COLLECT_B = 2'd1,
    ISSUE     = 2'd2
  } coll_state_e;

endpackage

// File: rtl/simt_operand_collector.sv
// Gathers A and B operand vectors beat by beat from the register file and
// presents them as full-width vectors to the lane bank for one issue.
module simt_operand_collector
  import simt_pkg::*;
#(
  parameter int LANES      = SIMT_LANES,
  parameter int WIDTH      = SIMT_WIDTH,
  parameter int BEAT_LANES = SIMT_BEAT_LANES,
  parameter int WID_W      = SIMT_WID_W
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        rf_valid,
  output logic                        rf_ready,
  input  logic [BEAT_LANES*WIDTH-1:0] rf_data,
  input  logic [WID_W-1:0]            rf_wid,
  output logic                        issue_valid,
  input  logic                        issue_ready,
  output logic [LANES*WIDTH-1:0]      a_flat,
  output logic [LANES*WIDTH-1:0]      b_flat,
  output logic [WID_W-1:0]            issue_wid,
  output logic                        err
);

  localparam int NB    = LANES / BEAT_LANES;
  localparam int CNT_W = (NB > 1) ? $clog2(NB) : 1;
  localparam int BW    = BEAT_LANES * WIDTH;

  coll_state_e            state_q;
  logic [CNT_W-1:0]       cnt_q;
  logic [WID_W-1:0]       wid_q;
  logic                   err_q;
  logic                   err_d;
  logic                   rf_ready_q;
  logic                   issue_valid_q;
  logic [LANES*WIDTH-1:0] a_q;
  logic [LANES*WIDTH-1:0] b_q;

  logic                   xfer;
  logic                   last_beat;
  logic                   first_a_beat;
  logic [NB-1:0]          a_we;
  logic [NB-1:0]          b_we;

  assign xfer         = rf_valid && rf_ready_q;
  assign last_beat    = (cnt_q == CNT_W'(NB - 1));
  assign first_a_beat = (state_q == COLLECT_A) && (cnt_q == '0);

  // Any accepted beat other than the first of A must carry the captured warp id.
  assign err_d = err_q || (xfer && !first_a_beat && (rf_wid != wid_q));

  generate
    for (genvar gi = 0; gi < NB; gi++) begin : g_we
      assign a_we[gi] = xfer && (state_q == COLLECT_A) && (cnt_q == CNT_W'(gi));
      assign b_we[gi] = xfer && (state_q == COLLECT_B) && (cnt_q == CNT_W'(gi));
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= COLLECT_A;
      cnt_q         <= '0;
      wid_q         <= '0;
      err_q         <= 1'b0;
      rf_ready_q    <= 1'b1;
      issue_valid_q <= 1'b0;
    end else begin
      err_q <= err_d;
      case (state_q)
        COLLECT_A: begin
          if (xfer) begin
            if (cnt_q == '0) wid_q <= rf_wid;
            if (last_beat) begin
              cnt_q   <= '0;
              state_q <= COLLECT_B;
            end else begin
              cnt_q <= cnt_q + CNT_W'(1);
            end
          end
        end
        COLLECT_B: begin
          if (xfer) begin
            if (last_beat) begin
              cnt_q         <= '0;
              state_q       <= ISSUE;
              rf_ready_q    <= 1'b0;
              issue_valid_q <= 1'b1;
            end else begin
              cnt_q <= cnt_q + CNT_W'(1);
            end
          end
        end
        ISSUE: begin
          if (issue_ready) begin
            state_q       <= COLLECT_A;
            rf_ready_q    <= 1'b1;
            issue_valid_q <= 1'b0;
          end
        end
        default: begin
          state_q       <= COLLECT_A;
          cnt_q         <= '0;
          rf_ready_q    <= 1'b1;
          issue_valid_q <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      a_q <= '0;
      b_q <= '0;
    end else begin
      for (int k = 0; k < NB; k++) begin
        if (a_we[k]) a_q[k*BW +: BW] <= rf_data;
        if (b_we[k]) b_q[k*BW +: BW] <= rf_data;
      end
    end
  end

  assign rf_ready    = rf_ready_q;
  assign issue_valid = issue_valid_q;
  assign a_flat      = a_q;
  assign b_flat      = b_q;
  assign issue_wid   = wid_q;
  assign err         = err_q;

endmodule

// File: tb/tb_simt_operand_collector.sv
// Self-checking bench: directed scenarios plus random traffic, compared every
// cycle against a beat-indexed warp model.
module tb_simt_operand_collector;

  localparam int LANES = 32;
  localparam int WIDTH = 32;
  localparam int BL    = 8;
  localparam int WID_W = 5;
  localparam int NB    = LANES / BL;

  logic                   clk = 1'b0;
  logic                   rst_n;
  logic                   rf_valid;
  logic                   rf_ready;
  logic [BL*WIDTH-1:0]    rf_data;
  logic [WID_W-1:0]       rf_wid;
  logic                   issue_valid;
  logic                   issue_ready;
  logic [LANES*WIDTH-1:0] a_flat;
  logic [LANES*WIDTH-1:0] b_flat;
  logic [WID_W-1:0]       issue_wid;
  logic                   err;

  simt_operand_collector #(
    .LANES(LANES), .WIDTH(WIDTH), .BEAT_LANES(BL), .WID_W(WID_W)
  ) dut (
    .clk(clk), .rst_n(rst_n), .rf_valid(rf_valid), .rf_ready(rf_ready),
    .rf_data(rf_data), .rf_wid(rf_wid), .issue_valid(issue_valid),
    .issue_ready(issue_ready), .a_flat(a_flat), .b_flat(b_flat),
    .issue_wid(issue_wid), .err(err)
  );

  always #5 clk = ~clk;

  // Model: a warp is 2*NB beats; beat n < NB fills A, the rest fill B.
  logic [WIDTH-1:0] m_a [LANES];
  logic [WIDTH-1:0] m_b [LANES];
  logic [WID_W-1:0] m_wid;
  bit               m_err;
  bit               m_pending;
  int               m_n;
  bit               m_init = 1'b0;

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic compare_all();
    check("rf_ready", 64'(rf_ready), 64'(!m_pending));
    check("issue_valid", 64'(issue_valid), 64'(m_pending));
    check("issue_wid", 64'(issue_wid), 64'(m_wid));
    check("err", 64'(err), 64'(m_err));
    for (int j = 0; j < LANES; j++) begin
      check("a_lane", 64'(a_flat[j*WIDTH +: WIDTH]), 64'(m_a[j]));
      check("b_lane", 64'(b_flat[j*WIDTH +: WIDTH]), 64'(m_b[j]));
    end
  endtask

  function automatic logic [BL*WIDTH-1:0] pat_data(input int n);
    logic [BL*WIDTH-1:0] d;
    int lane;
    for (int j = 0; j < BL; j++) begin
      lane = (n % NB) * BL + j;
      d[j*WIDTH +: WIDTH] = (n < NB) ? WIDTH'(lane) : WIDTH'(100 + lane);
    end
    return d;
  endfunction

  // One clock: check outputs at the falling edge, drive inputs, advance model.
  task automatic step(input logic rstn, input logic v, input logic [WID_W-1:0] w,
                      input logic ir, input logic [BL*WIDTH-1:0] d);
    int lane;
    @(negedge clk);
    if (m_init) compare_all();
    rst_n = rstn; rf_valid = v; rf_wid = w; issue_ready = ir; rf_data = d;
    if (!rstn) begin
      for (int j = 0; j < LANES; j++) begin
        m_a[j] = '0;
        m_b[j] = '0;
      end
      m_wid = '0; m_err = 1'b0; m_pending = 1'b0; m_n = 0; m_init = 1'b1;
    end else if (m_pending) begin
      if (ir) m_pending = 1'b0;
    end else if (v) begin
      for (int j = 0; j < BL; j++) begin
        lane = (m_n % NB) * BL + j;
        if (m_n < NB) m_a[lane] = d[j*WIDTH +: WIDTH];
        else          m_b[lane] = d[j*WIDTH +: WIDTH];
      end
      if (m_n == 0) m_wid = w;
      else if (w != m_wid) m_err = 1'b1;
      m_n++;
      if (m_n == 2 * NB) begin
        m_n = 0;
        m_pending = 1'b1;
      end
    end
    @(posedge clk);
    #1;
  endtask

  // Streams patterned beats with issue_ready low until the DUT raises issue_valid.
  task automatic run_until_issue(input logic [WID_W-1:0] w, input bit toggle,
                                 input int odd_beat, output int edges);
    logic [WID_W-1:0] wv;
    edges = 0;
    while (issue_valid !== 1'b1 && edges < 64) begin
      wv = (m_n == odd_beat) ? w + WID_W'(1) : w;
      step(1'b1, toggle ? ((edges % 2) == 0) : 1'b1, wv, 1'b0, pat_data(m_n));
      edges++;
    end
    if (edges >= 64) check("issue_timeout", 64'(issue_valid), 64'd1);
  endtask

  initial begin
    int edges;
    int nissue;
    int issue_at [2];
    logic [BL*WIDTH-1:0] rd;
    logic [WID_W-1:0] rw;

    rst_n = 1'b0; rf_valid = 1'b0; rf_wid = '0; issue_ready = 1'b0; rf_data = '0;
    step(1'b0, 1'b0, '0, 1'b0, '0);
    step(1'b0, 1'b0, '0, 1'b0, '0);
    check("reset_rf_ready", 64'(rf_ready), 64'd1);
    check("reset_issue_valid", 64'(issue_valid), 64'd0);
    check("reset_a0", 64'(a_flat[0 +: WIDTH]), 64'd0);

    // Full-rate warp; issue_valid in cycle 9 after the first beat.
    run_until_issue(5'd3, 1'b0, -1, edges);
    check("latency_full_rate", 64'(edges), 64'(2 * NB));
    check("a_lane31", 64'(a_flat[31*WIDTH +: WIDTH]), 64'd31);
    check("b_lane0", 64'(b_flat[0 +: WIDTH]), 64'd100);
    check("wid_full_rate", 64'(issue_wid), 64'd3);
    check("err_clean", 64'(err), 64'd0);
    // Back-pressure: hold five cycles, then hand over.
    repeat (5) step(1'b1, 1'b1, 5'd3, 1'b0, pat_data(0));
    check("held_valid", 64'(issue_valid), 64'd1);
    step(1'b1, 1'b0, 5'd3, 1'b1, '0);
    check("released", 64'(issue_valid), 64'd0);

    // Half-rate delivery: issue 1 cycle after the 8th transfer.
    run_until_issue(5'd3, 1'b1, -1, edges);
    check("latency_toggle", 64'(edges), 64'(4 * NB - 1));
    check("a_lane31_toggle", 64'(a_flat[31*WIDTH +: WIDTH]), 64'd31);
    step(1'b1, 1'b0, 5'd3, 1'b1, '0);

    // Warp-id mismatch on beat 5 sets a sticky error.
    run_until_issue(5'd3, 1'b0, 5, edges);
    check("err_set", 64'(err), 64'd1);
    check("wid_kept", 64'(issue_wid), 64'd3);
    step(1'b1, 1'b0, 5'd3, 1'b1, '0);
    run_until_issue(5'd7, 1'b0, -1, edges);
    check("err_sticky", 64'(err), 64'd1);
    step(1'b1, 1'b0, 5'd7, 1'b1, '0);

    // Reset after five beats discards the partial warp.
    for (int k = 0; k < 5; k++) step(1'b1, 1'b1, 5'd3, 1'b0, pat_data(m_n));
    step(1'b0, 1'b1, 5'd3, 1'b0, '0);
    check("rst_mid_valid", 64'(issue_valid), 64'd0);
    check("rst_mid_a0", 64'(a_flat[0 +: WIDTH]), 64'd0);
    check("rst_mid_ready", 64'(rf_ready), 64'd1);
    run_until_issue(5'd3, 1'b0, -1, edges);
    check("after_rst_latency", 64'(edges), 64'(2 * NB));
    step(1'b1, 1'b0, 5'd3, 1'b1, '0);

    // Back-to-back warps with issue_ready held high.
    nissue = 0;
    edges  = 0;
    while (nissue < 2 && edges < 64) begin
      step(1'b1, 1'b1, (nissue == 0) ? 5'd1 : 5'd2, 1'b1, pat_data(m_n));
      edges++;
      if (issue_valid === 1'b1) begin
        issue_at[nissue] = edges;
        check("b2b_wid", 64'(issue_wid), (nissue == 0) ? 64'd1 : 64'd2);
        nissue++;
      end
    end
    check("b2b_count", 64'(nissue), 64'd2);
    if (nissue == 2) check("b2b_spacing", 64'(issue_at[1] - issue_at[0]), 64'(2 * NB + 1));

    // Random traffic, occasional wid glitches and resets.
    for (int c = 0; c < 500; c++) begin
      for (int j = 0; j < BL; j++) rd[j*WIDTH +: WIDTH] = $urandom;
      if (m_n == 0) rw = WID_W'($urandom);
      else rw = ($urandom_range(0, 19) == 0) ? WID_W'($urandom) : m_wid;
      step(($urandom_range(0, 99) != 0), ($urandom_range(0, 9) < 7), rw,
           ($urandom_range(0, 9) < 6), rd);
    end
    @(negedge clk);
    compare_all();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
